tpu_banked_buf_mp: RTL



---
 rtl/tpu_buf_pkg.sv | 28 ++
 rtl/tpu_bank_sram.sv | 31 +++
 rtl/tpu_banked_buf_mp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tpu_buf_pkg.sv
// Shared types and address helpers for the banked ping-pong buffer.
//   phys_bank_t  : physical bank index {set, bank}; wide enough for 2*16 banks
//   swap_state_e : swap handshake states
//   bank_bits    : log2 of the bank count
//   addr_bank    : low-order interleave bank select
//   addr_row     : row within a bank
package tpu_buf_pkg;

  typedef logic [4:0] phys_bank_t;

  typedef enum logic [0:0] {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

  function automatic int bank_bits(input int nb);
    return $clog2(nb);
  endfunction

  function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int nb);
    return addr & 32'(nb - 1);
  endfunction

  function automatic logic [31:0] addr_row(input logic [31:0] addr, input int nb);
    return addr >> bank_bits(nb);
  endfunction

endpackage

// File: rtl/tpu_bank_sram.sv
// One bank of the buffer: single-port 1RW SRAM with a registered read.
//   clk   : clock
//   en    : access enable (read or write)
//   we    : 1 = write, 0 = read
//   row   : word row within the bank
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; holds otherwise
module tpu_bank_sram #(
  parameter int ROWS   = 256,
  parameter int DATA_W = 32,
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ROWS];

  // Storage is intentionally unreset; contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    rdata    <= mem[row];
    end
  end

endmodule

// File: rtl/tpu_banked_buf_mp.sv
// Multi-port banked buffer with an active/shadow set pair.
//   clk, rst_n   : clock, async active-low reset
//   req_*        : per-port request (valid, wr, shadow select, word addr, wdata)
//   req_ready    : combinational per-port grant
//   rsp_valid    : read data valid, one cycle after an accepted read
//   rsp_rdata    : packed read data, zero when rsp_valid is low
//   swap_req     : request active/shadow exchange
//   swap_ack     : one-cycle pulse alongside the new active_set
//   active_set   : physical set currently acting as the active set
//   cnt_clear    : synchronous clear of conflict_cnt (wins over increment)
//   conflict_cnt : saturating count of lost arbitrations
module tpu_banked_buf_mp
  import tpu_buf_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int NUM_BANKS = 8,
  parameter int DEPTH     = 2048,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_wr,
  input  logic [NUM_PORTS-1:0]        req_shadow,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rsp_rdata,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        active_set,
  input  logic                        cnt_clear,
  output logic [31:0]                 conflict_cnt
);

  localparam int BANK_W = bank_bits(NUM_BANKS);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int ROWS   = DEPTH / NUM_BANKS;
  localparam int NPB    = 2 * NUM_BANKS;
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int LOSE_W = PORT_W + 1;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0][ROW_W-1:0]  row;
  phys_bank_t                       pb [NUM_PORTS];

  assign addr  = req_addr;
  assign wdata = req_wdata;

  // Per-port address decode into physical bank and row.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [BANK_W-1:0] bk;
    assign bk     = BANK_W'(addr_bank(32'(addr[p]), NUM_BANKS));
    assign row[p] = ROW_W'(addr_row(32'(addr[p]), NUM_BANKS));
    assign pb[p]  = phys_bank_t'({active_set ^ req_shadow[p], bk});
  end

  swap_state_e                  state;
  logic                         swap_pend;
  logic [PORT_W-1:0]            rr_ptr;
  logic [PORT_W-1:0]            idx;
  logic [NUM_PORTS-1:0]         gnt;
  logic [NPB-1:0]               win_vld;
  logic [NPB-1:0][PORT_W-1:0]   win_port;
  logic [NPB-1:0][DATA_W-1:0]   bk_rdata;
  logic [NUM_PORTS-1:0]         lose;
  logic [LOSE_W-1:0]            n_lose;
  logic [32:0]                  cnt_sum;
  phys_bank_t                   rsp_pb [NUM_PORTS];
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  assign swap_pend = (state == SWAP_PEND);

  // Per physical bank: first valid port at or after rr_ptr, scanning
  // cyclically. A port targets exactly one bank, so gnt has no overlaps.
  always_comb begin
    gnt      = '0;
    win_vld  = '0;
    win_port = '0;
    idx      = '0;
    for (int b = 0; b < NPB; b++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = rr_ptr + PORT_W'(i);
        if (!win_vld[b] && req_valid[idx] && pb[idx] == phys_bank_t'(b)) begin
          win_vld[b]  = 1'b1;
          win_port[b] = idx;
          gnt[idx]    = 1'b1;
        end
      end
    end
  end

  assign req_ready = gnt & {NUM_PORTS{!swap_pend}};

  // Banks are idle during the swap cycle so neither set changes under it.
  for (genvar b = 0; b < NPB; b++) begin : g_bank
    tpu_bank_sram #(.ROWS(ROWS), .DATA_W(DATA_W)) u_sram (
      .clk   (clk),
      .en    (win_vld[b] && !swap_pend),
      .we    (req_wr[win_port[b]]),
      .row   (row[win_port[b]]),
      .wdata (wdata[win_port[b]]),
      .rdata (bk_rdata[b])
    );
  end

  // Losers are not counted while the swap holds everyone off.
  assign lose = swap_pend ? '0 : (req_valid & ~gnt);

  always_comb begin
    n_lose = '0;
    for (int p = 0; p < NUM_PORTS; p++) n_lose = n_lose + LOSE_W'(lose[p]);
  end

  assign cnt_sum = {1'b0, conflict_cnt} + 33'(n_lose);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SWAP_IDLE;
      active_set   <= 1'b0;
      swap_ack     <= 1'b0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
      rsp_valid    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rsp_pb[p] <= '0;
    end else begin
      swap_ack <= swap_pend;
      if (swap_pend) begin
        state      <= SWAP_IDLE;
        active_set <= ~active_set;
      end else if (swap_req) begin
        state <= SWAP_PEND;
      end

      if (cnt_clear)  conflict_cnt <= '0;
      else if (|lose) conflict_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];

      if (|lose) rr_ptr <= rr_ptr + 1'b1;

      // Remember the physical bank so a swap next cycle cannot misroute data.
      rsp_valid <= req_ready & ~req_wr;
      for (int p = 0; p < NUM_PORTS; p++)
        if (req_ready[p]) rsp_pb[p] <= pb[p];
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int b = 0; b < NPB; b++)
        if (rsp_valid[p] && rsp_pb[p] == phys_bank_t'(b)) rdata[p] = bk_rdata[b];
  end

  assign rsp_rdata = rdata;

endmodule
